// File: rtl/indirect_mem_sequencer.sv
// MEM-stage access sequencer for the LC-3b: direct and indirect (pointer-then-data)
// loads/stores with word or byte granularity and a per-phase response timeout.
module indirect_mem_sequencer #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic               byte_en,
  input  logic [WIDTH-1:0]   addr,
  input  logic [WIDTH-1:0]   wdata,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [WIDTH-1:0]   rdata_out,
  output logic               mem_read,
  output logic               mem_write,
  output logic [WIDTH-1:0]   mem_address,
  output logic [WIDTH-1:0]   mem_wdata,
  output logic [WIDTH/8-1:0] mem_byte_enable,
  input  logic               mem_resp,
  input  logic [WIDTH-1:0]   mem_rdata
);

  localparam int unsigned LANES = WIDTH / 8;
  localparam int unsigned LB    = $clog2(LANES);
  localparam int unsigned CW    = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, PTR_RD, FINAL, DONE} state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             byte_q, byte_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [CW-1:0]    wait_q, wait_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] aligned_addr;
  logic [LANES-1:0] lane_mask;
  logic [7:0]       lane_byte;
  logic [WIDTH-1:0] wdata_rep;
  logic             timeout;

  // Lane decode: one-hot enable, read-lane extraction and store-byte replication.
  always_comb begin
    aligned_addr = {addr_q[WIDTH-1:LB], {LB{1'b0}}};
    lane_mask    = '0;
    lane_byte    = '0;
    wdata_rep    = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      wdata_rep[i*8 +: 8] = wdata_q[7:0];
      if (addr_q[LB-1:0] == LB'(i)) begin
        lane_mask[i] = 1'b1;
        lane_byte    = mem_rdata[i*8 +: 8];
      end
    end
  end

  assign timeout = (wait_q == CW'(MAX_WAIT - 1));

  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    byte_d          = byte_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    rdata_d         = rdata_q;
    wait_d          = wait_q;
    err_d           = err_q;
    busy            = 1'b0;
    done            = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = aligned_addr;
    mem_wdata       = wdata_q;
    mem_byte_enable = '1;

    case (state_q)
      IDLE: begin
        busy = start;
        if (start) begin
          op_d    = op;
          byte_d  = byte_en;
          addr_d  = addr;
          wdata_d = wdata;
          wait_d  = '0;
          err_d   = 1'b0;
          state_d = op[1] ? PTR_RD : FINAL;
        end
      end
      PTR_RD: begin
        busy     = 1'b1;
        mem_read = 1'b1;
        if (mem_resp) begin
          addr_d  = mem_rdata;
          wait_d  = '0;
          state_d = FINAL;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      FINAL: begin
        busy      = 1'b1;
        mem_read  = !op_q[0];
        mem_write = op_q[0];
        if (byte_q) begin
          mem_address     = addr_q;
          mem_byte_enable = lane_mask;
          mem_wdata       = wdata_rep;
        end
        if (mem_resp) begin
          if (!op_q[0]) rdata_d = byte_q ? WIDTH'(lane_byte) : mem_rdata;
          state_d = DONE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  assign rdata_out = rdata_q;
  assign err       = err_q;

endmodule

// File: doc/indirect_mem_sequencer.md
Name: indirect_mem_sequencer

Overview:
- Multi-cycle memory-access sequencer for the MEM stage of the LC-3b pipeline.
- Executes direct loads/stores and the indirect forms (LDI/STI), which need a pointer read followed by the final access.
- Supports word and byte access at parametrised width, with a response timeout.
- Stalls the pipeline via busy until the access completes.

Parameters:
- WIDTH, 16, data/address width; must be a power-of-two multiple of 8, at least 16.
- MAX_WAIT, 255, max cycles spent in one memory phase without mem_resp before abort; at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  MEM stage presents an access (sampled in IDLE only)
- op  in  2  00 load, 01 store, 10 load-indirect, 11 store-indirect
- byte_en  in  1  final access is byte-sized
- addr  in  WIDTH  effective address (or pointer address for indirect)
- wdata  in  WIDTH  store data
- busy  out  1  stall request to upstream stages
- done  out  1  one-cycle completion pulse
- err  out  1  completion was a timeout abort (valid with done)
- rdata_out  out  WIDTH  load result
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_address  out  WIDTH  memory address
- mem_wdata  out  WIDTH  memory write data
- mem_byte_enable  out  WIDTH/8  lane mask
- mem_resp  in  1  memory response (one-cycle)
- mem_rdata  in  WIDTH  memory read data

Behaviour:
- Reset is synchronous and active-high; one clock, clk.
- Reset values: state IDLE; done, err, mem_read, mem_write = 0; rdata_out, mem_address, mem_wdata, internal registers = 0; mem_byte_enable = all ones.
- States: IDLE, PTR_RD, FINAL, DONE.
- IDLE:
  - busy = start (combinational).
  - On start, register op, byte_en, addr, wdata and clear the wait counter.
  - Go to PTR_RD if op[1] = 1, else go to FINAL.
- PTR_RD:
  - mem_read = 1; mem_address = addr_reg with the low log2(WIDTH/8) bits cleared; mem_byte_enable = all ones; busy = 1.
  - On mem_resp: addr_reg <= mem_rdata, clear the wait counter, go to FINAL.
- FINAL:
  - mem_read = !op_reg[0]; mem_write = op_reg[0]; busy = 1.
  - Word access: address aligned as in PTR_RD; byte_enable all ones; mem_wdata = wdata_reg.
  - Byte access: mem_address = addr_reg unmodified; lane L = addr_reg low bits; byte_enable one-hot at L; mem_wdata = wdata_reg[7:0] replicated across all lanes.
  - On mem_resp: loads capture rdata_out (word: mem_rdata; byte: lane L zero-extended); stores leave rdata_out unchanged. Go to DONE.
- DONE:
  - done = 1 for exactly one cycle; busy = 0; start ignored; go to IDLE.
  - Upstream advances in this cycle; the next access arrives at the earliest in the following IDLE cycle.
- Timeout:
  - Wait counter increments each PTR_RD/FINAL cycle without mem_resp.
  - If the counter equals MAX_WAIT-1 with no mem_resp, go to DONE with err = 1; rdata_out is unchanged.
  - A request is therefore held for exactly MAX_WAIT cycles.
  - mem_resp in that same cycle takes precedence (normal completion).
  - err is cleared on the next accepted start.
- mem_resp outside PTR_RD/FINAL is ignored.
- mem_read and mem_write are never both high.
- Request outputs are registered from state, so they drop in the cycle after the resp cycle.
- Latency, zero-wait memory (resp in the first request cycle):
  - Direct access: start at cycle t, DONE at t+2.
  - Indirect access: DONE at t+3.
  - Each wait cycle adds 1.
- Reset mid-operation:
  - Next cycle is IDLE; requests deassert; no done pulse.
  - Captured data is discarded; rdata_out is reset to 0.

Test Plan:
- Word load, WIDTH=16, addr 0x1235, resp after 2 wait cycles with 0xBEEF -> mem_address 0x1234, byte_enable 2'b11, mem_read held 3 cycles, done at t+4, rdata_out 0xBEEF, err 0.
- Byte load, addr 0x2001, mem_rdata 0xA55A, zero-wait -> byte_enable 2'b10, rdata_out 0x00A5, done at t+2, busy high t..t+1, low at t+2.
- LDI, addr 0x3000; pointer read returns 0x4002; final read at 0x4002 returns 0x1111 -> two read phases, done at t+3, rdata_out 0x1111.
- Byte STI, addr 0x3000, pointer 0x5003, wdata 0x00C3 -> final mem_write = 1, mem_address 0x5003, byte_enable 2'b10, mem_wdata 0xC3C3, rdata_out unchanged.
- Timeout, MAX_WAIT=4, no resp -> mem_read high exactly 4 cycles, then done = 1 and err = 1; resp injected on the 4th cycle instead -> err = 0.
- rst asserted during PTR_RD -> next cycle IDLE, mem_read 0, done never pulses, rdata_out 0; a following start behaves normally.
